// File: rtl/mem_rv_pkg.sv
// mem_rv_pkg: shared types and constants for the handshaked word memory.
// Holds the default word width, the op enum and the response record.
package mem_rv_pkg;

    localparam int DEFAULT_WORD_W        = 8;
    localparam int MEM_RV_MAX_RESP_DEPTH = 16;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_op_e;

    typedef struct packed {
        logic [DEFAULT_WORD_W-1:0] rdata;
        logic                      write;
        logic                      err;
    } mem_rsp_t;

endpackage

// File: rtl/mem_rv_if.sv
// mem_rv_if: valid/ready request and response channels of mem_rv_module.
// master = requester side, slave = memory side; req_wstrb only with MEM_RV_WSTRB_EN.
interface mem_rv_if
    import mem_rv_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = DEFAULT_WORD_W
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
`ifdef MEM_RV_WSTRB_EN
    logic [DATA_WIDTH/8-1:0] req_wstrb;
`endif
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_write;
    logic                  rsp_err;

`ifdef MEM_RV_WSTRB_EN
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_write, rsp_err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_write, rsp_err
    );
`else
    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_write, rsp_err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_write, rsp_err
    );
`endif

endinterface

// File: rtl/mem_rv_rsp_fifo.sv
// mem_rv_rsp_fifo: response FIFO, DEPTH entries of type T (default mem_rsp_t).
// Ports: clk, rst_n, i_push/i_data, i_pop, o_head, o_full, o_empty.
module mem_rv_rsp_fifo
    import mem_rv_pkg::*;
#(
    parameter type T     = mem_rsp_t,
    parameter int  DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T              r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // Wrap explicitly so non-power-of-2 depths work.
    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= f_inc(r_wptr);
            if (i_pop)  r_rptr <= f_inc(r_rptr);
            if (i_push && !i_pop)      r_count <= r_count + CW'(1);
            else if (!i_push && i_pop) r_count <= r_count - CW'(1);
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/mem_rv_module.sv
// mem_rv_module: single-port word memory with valid/ready req/rsp channels.
// Ports: clk, rst_n (async low), bus (mem_rv_if.slave). MEM_RV_WSTRB_EN enables byte strobes.
module mem_rv_module
    import mem_rv_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 2**ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_WORD_W,
    parameter int RESP_DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    mem_rv_if.slave bus
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  write;
        logic                  err;
    } rsp_t;

    localparam int OW = $clog2(RESP_DEPTH + 1);

    if (DEPTH < 1 || DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
        $error("mem_rv_module: DEPTH out of range");
    end
    if (RESP_DEPTH < 2 || RESP_DEPTH > MEM_RV_MAX_RESP_DEPTH) begin : g_bad_rd
        $error("mem_rv_module: RESP_DEPTH out of range");
    end
`ifdef MEM_RV_WSTRB_EN
    if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
        $error("mem_rv_module: DATA_WIDTH must be a multiple of 8");
    end
`endif

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [OW-1:0]         r_outst;

    mem_op_e               w_op;
    logic                  w_is_wr;
    logic                  w_in_range;
    logic                  w_req_fire;
    logic                  w_rsp_fire;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_new;
    rsp_t                  w_push_data;
    rsp_t                  w_head;

    assign w_op       = mem_op_e'(bus.req_write);
    assign w_is_wr    = (w_op == MEM_WRITE);
    assign w_in_range = ({1'b0, bus.req_addr} < (ADDR_WIDTH + 1)'(DEPTH));

    // Ready comes only from the registered count: no path from rsp_ready.
    assign bus.req_ready = (r_outst < OW'(RESP_DEPTH));
    assign w_req_fire    = bus.req_valid & bus.req_ready & ~w_full;
    assign w_rsp_fire    = bus.rsp_valid & bus.rsp_ready;

    assign w_old = r_mem[bus.req_addr];

`ifdef MEM_RV_WSTRB_EN
    always_comb begin
        w_new = w_old;
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (bus.req_wstrb[b]) w_new[b*8 +: 8] = bus.req_wdata[b*8 +: 8];
        end
    end
`else
    assign w_new = bus.req_wdata;
`endif

    // Array deliberately unreset: contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_req_fire && w_is_wr && w_in_range) r_mem[bus.req_addr] <= w_new;
    end

    always_comb begin
        w_push_data       = '0;
        w_push_data.write = w_is_wr;
        w_push_data.err   = ~w_in_range;
        if (!w_is_wr && w_in_range) w_push_data.rdata = w_old;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outst <= '0;
        end else if (w_req_fire && !w_rsp_fire) begin
            r_outst <= r_outst + OW'(1);
        end else if (!w_req_fire && w_rsp_fire) begin
            r_outst <= r_outst - OW'(1);
        end
    end

    mem_rv_rsp_fifo #(
        .T     (rsp_t),
        .DEPTH (RESP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_req_fire),
        .i_data  (w_push_data),
        .i_pop   (w_rsp_fire),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Head fields are forced to 0 while nothing is queued.
    assign bus.rsp_valid = ~w_empty;
    assign bus.rsp_rdata = w_empty ? '0 : w_head.rdata;
    assign bus.rsp_write = ~w_empty & w_head.write;
    assign bus.rsp_err   = ~w_empty & w_head.err;

endmodule

// File: tb/tb_mem_rv_module.sv
// tb_mem_rv_module: directed self-checking bench for mem_rv_module.
// DEPTH=20, RESP_DEPTH=2; DATA_WIDTH=16 when MEM_RV_WSTRB_EN is defined.
module tb_mem_rv_module;

`ifdef MEM_RV_WSTRB_EN
    localparam int DW = 16;
`else
    localparam int DW = 8;
`endif
    localparam int AW    = 5;
    localparam int DEPTH = 20;
    localparam int RD    = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] exp_mem [DEPTH];

    always #5 clk = ~clk;

    mem_rv_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_rv_module #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .RESP_DEPTH (RD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic w,
                           input logic e, input logic [DW-1:0] d);
        chk({tag, ".valid"}, 32'(bus.rsp_valid), 32'(v));
        chk({tag, ".write"}, 32'(bus.rsp_write), 32'(w));
        chk({tag, ".err"},   32'(bus.rsp_err),   32'(e));
        chk({tag, ".rdata"}, 32'(bus.rsp_rdata), 32'(d));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
    endtask

    initial begin
        drive(1'b0, 1'b0, '0, '0);
        bus.rsp_ready = 1'b1;
`ifdef MEM_RV_WSTRB_EN
        bus.req_wstrb = '1;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
        chk_rsp("rst", 1'b0, 1'b0, 1'b0, '0);
        #3 rst_n = 1'b1;
        step();

        // write then read addr 3, latency 1
        drive(1'b1, 1'b1, 5'd3, DW'('hA5));
        chk("wr3.ready", 32'(bus.req_ready), 32'd1);
        step();
        exp_mem[3] = DW'('hA5);
        drive(1'b1, 1'b0, 5'd3, '0);
        chk_rsp("wr3.rsp", 1'b1, 1'b1, 1'b0, '0);
        step();
        drive(1'b0, 1'b0, '0, '0);
        chk_rsp("rd3.rsp", 1'b1, 1'b0, 1'b0, DW'('hA5));
        step();
        chk("rd3.drained", 32'(bus.rsp_valid), 32'd0);

        // back-to-back write/read of addr 7
        drive(1'b1, 1'b1, 5'd7, DW'('h3C));
        step();
        exp_mem[7] = DW'('h3C);
        drive(1'b1, 1'b0, 5'd7, '0);
        chk("b2b.ready", 32'(bus.req_ready), 32'd1);
        step();
        drive(1'b0, 1'b0, '0, '0);
        chk_rsp("b2b.rd", 1'b1, 1'b0, 1'b0, DW'('h3C));
        step();

        // fill all words at full throughput
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b1, AW'(i), DW'(i * 7 + 1));
            chk($sformatf("fill%0d.ready", i), 32'(bus.req_ready), 32'd1);
            step();
            exp_mem[i] = DW'(i * 7 + 1);
        end
        drive(1'b0, 1'b0, '0, '0);
        step();
        chk("fill.drained", 32'(bus.rsp_valid), 32'd0);

        // out-of-range read and write
        drive(1'b1, 1'b0, 5'd25, '0);
        step();
        drive(1'b1, 1'b1, 5'd25, DW'('hFF));
        chk_rsp("oor.rd", 1'b1, 1'b0, 1'b1, '0);
        step();
        drive(1'b0, 1'b0, '0, '0);
        chk_rsp("oor.wr", 1'b1, 1'b1, 1'b1, '0);
        step();

        // back-pressure: two accepted, then stall
        bus.rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 5'd0, '0);
        chk("bp.rdy0", 32'(bus.req_ready), 32'd1);
        step();
        drive(1'b1, 1'b0, 5'd1, '0);
        chk("bp.rdy1", 32'(bus.req_ready), 32'd1);
        step();
        drive(1'b1, 1'b0, 5'd2, '0);
        chk("bp.rdy_low", 32'(bus.req_ready), 32'd0);
        chk_rsp("bp.head0", 1'b1, 1'b0, 1'b0, exp_mem[0]);
        step();
        chk("bp.rdy_low2", 32'(bus.req_ready), 32'd0);
        chk_rsp("bp.head0_hold", 1'b1, 1'b0, 1'b0, exp_mem[0]);
        bus.rsp_ready = 1'b1;
        step();
        chk_rsp("bp.head1", 1'b1, 1'b0, 1'b0, exp_mem[1]);
        chk("bp.rdy_back", 32'(bus.req_ready), 32'd1);
        step();
        drive(1'b1, 1'b0, 5'd3, '0);
        chk_rsp("bp.head2", 1'b1, 1'b0, 1'b0, exp_mem[2]);
        step();
        drive(1'b0, 1'b0, '0, '0);
        chk_rsp("bp.head3", 1'b1, 1'b0, 1'b0, exp_mem[3]);
        step();
        chk("bp.drained", 32'(bus.rsp_valid), 32'd0);

        // reset with two responses queued
        bus.rsp_ready = 1'b0;
        drive(1'b1, 1'b1, 5'd6, DW'('h5A));
        step();
        exp_mem[6] = DW'('h5A);
        drive(1'b1, 1'b0, 5'd5, '0);
        step();
        drive(1'b0, 1'b0, '0, '0);
        chk("rstq.ready", 32'(bus.req_ready), 32'd0);
        chk("rstq.valid", 32'(bus.rsp_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk_rsp("rstq.flush", 1'b0, 1'b0, 1'b0, '0);
        chk("rstq.ready_now", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        step();
        drive(1'b1, 1'b0, 5'd6, '0);
        step();
        drive(1'b0, 1'b0, '0, '0);
        chk_rsp("rstq.keep6", 1'b1, 1'b0, 1'b0, DW'('h5A));
        step();

`ifdef MEM_RV_WSTRB_EN
        // byte strobes
        bus.req_wstrb = 2'b11;
        drive(1'b1, 1'b1, 5'd2, DW'('h1234));
        step();
        bus.req_wstrb = 2'b01;
        drive(1'b1, 1'b1, 5'd2, DW'('hABCD));
        step();
        bus.req_wstrb = 2'b00;
        drive(1'b1, 1'b1, 5'd2, DW'('hFFFF));
        chk_rsp("strb.wr01", 1'b1, 1'b1, 1'b0, '0);
        step();
        bus.req_wstrb = 2'b11;
        drive(1'b1, 1'b0, 5'd2, '0);
        chk_rsp("strb.wr00", 1'b1, 1'b1, 1'b0, '0);
        step();
        drive(1'b0, 1'b0, '0, '0);
        chk_rsp("strb.rd", 1'b1, 1'b0, 1'b0, DW'('h12CD));
        step();
        exp_mem[2] = DW'('h12CD);
`endif

        // sweep: contents survive reset and out-of-range writes
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, AW'(i), '0);
            step();
            drive(1'b0, 1'b0, '0, '0);
            chk($sformatf("sweep%0d", i), 32'(bus.rsp_rdata), 32'(exp_mem[i]));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_rv_module.md
# mem_rv_module

Parametrised single-port word memory with valid/ready request and response channels, in-order responses, out-of-range error reporting and an optional per-byte write strobe. It is the handshaked successor of the team's plain read/write memory: any pipeline stage that needs scratch storage connects to it, and back-pressure propagates both ways.

## Interface
- ADDR_WIDTH, 5, request address width.
- DEPTH, 2**ADDR_WIDTH, number of implemented words; legal range 1..2**ADDR_WIDTH.
- DATA_WIDTH, DEFAULT_WORD_W (8), word width.
- RESP_DEPTH, 2, response FIFO entries; legal range 2..16.
- clk  in  1  single clock; all logic samples on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on an edge where req_valid=1.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_wstrb  in  DATA_WIDTH/8  byte write strobes; present only with MEM_RV_WSTRB_EN.
- rsp_valid  out  1  response at FIFO head.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_write  out  1  response belongs to a write.
- rsp_err  out  1  address was >= DEPTH.

## Operation
- Every accepted request produces exactly one response; responses return in acceptance order.
- Outstanding counter `outst` (0..RESP_DEPTH): +1 on request handshake, -1 on response handshake, unchanged when both happen together.
- req_ready = (outst < RESP_DEPTH); depends only on registered state, with no combinational path from rsp_ready or req_valid.
- Read, addr < DEPTH: mem[addr] is pushed into the FIFO with err=0, write=0.
- Write, addr < DEPTH: mem[addr] is updated and a response with rdata=0, err=0, write=1 is pushed.
- Any op with addr >= DEPTH: memory untouched; response has rdata=0, err=1, write=req_write.
- rsp_rdata, rsp_write and rsp_err reflect the FIFO head and are 0 whenever rsp_valid=0.
- Memory array has no reset: contents persist through rst_n assertion and are undefined after power-up.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_write=0, rsp_err=0, outst=0, FIFO pointers 0.
- Reset asserted mid-operation: all queued responses are discarded immediately (asynchronously). A write accepted on an edge before reset asserted stays committed.

## Timing
- Request handshake on edge E0 → response visible (rsp_valid=1) in the cycle after E0 if the FIFO was empty: latency 1.
- Write at E0 followed by a read of the same address at E1 returns the new data; no read-during-write hazard exists because there is one port.
- With RESP_DEPTH>=2 and rsp_ready held at 1, throughput is one request per cycle.
- rsp_ready=0: FIFO fills; req_ready drops in the cycle after outst reaches RESP_DEPTH. rsp_valid and the head data stay stable until the response handshake.
- FIFO pointers wrap modulo RESP_DEPTH; full and empty are derived from the count, so non-power-of-2 depths are legal.

## Configuration
- MEM_RV_WSTRB_EN defined:
  - req_wstrb port exists; DATA_WIDTH must be a multiple of 8 (elaboration-time check).
  - A write updates only the bytes whose strobe bit is 1.
  - A write with all strobes 0 still produces a normal write response.
- MEM_RV_WSTRB_EN undefined: no req_wstrb port; every write updates the full word. Any DATA_WIDTH >= 1 is legal.

## Structure
- Package typedefs (shared):
  - Existing DEFAULT_WORD_W.
  - Enum mem_op_e {MEM_READ, MEM_WRITE}.
  - Packed struct mem_rsp_t {rdata, write, err} parameterised via DEFAULT_WORD_W.
  - Constant MEM_RV_MAX_RESP_DEPTH = 16.
- One sub-module, mem_rv_rsp_fifo: synchronous FIFO of mem_rsp_t with push, pop, count, full and empty. It uses the same clk and rst_n.
- Top level holds the array, address range check, strobe merge and outst counter.

## Test plan
- Reset, then write 0xA5 to addr 3, then read addr 3 with rsp_ready=1 → write response (write=1, rdata=0, err=0) one cycle after acceptance, then read response rdata=0xA5.
- Back-to-back write 0x3C to addr 7 at E0 and read addr 7 at E1 → read returns 0x3C; one request accepted per cycle.
- DEPTH=20, read addr 25 → err=1, rdata=0. Write 0xFF to addr 25 → err=1, write=1, and memory is unchanged (a later sweep reads back the prior contents).
- rsp_ready=0 with 4 reads issued, RESP_DEPTH=2 → req_ready low after 2 acceptances. Raising rsp_ready drains 2 in order, then the remaining 2 are accepted.
- Assert rst_n low with 2 responses queued → rsp_valid=0 and req_ready=1 immediately. After release, a read of a previously written address returns its old value.
- With MEM_RV_WSTRB_EN, DATA_WIDTH=16: write 0x1234, then write 0xABCD with wstrb=2'b01 → readback 0x12CD.
